bp_nbf_mem_arbiter: RTL and testbench



---
 rtl/bp_nbf_mem_arbiter_if.sv | 45 ++++
 rtl/bp_nbf_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bp_nbf_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_nbf_mem_arbiter_if.sv
// Bundled command/response handshakes between the NBF loader, the core memory
// port, downstream memory and bp_nbf_mem_arbiter (slave = arbiter side).
interface bp_nbf_mem_arbiter_if #(
    // Default matches cce_mem_msg_width(e_bp_default_cfg) in bp_nbf_mem_arbiter_pkg.
    parameter int unsigned msg_width_p = 569
);
    logic [msg_width_p-1:0] req0_cmd_i;
    logic                   req0_cmd_v_i;
    logic                   req0_cmd_yumi_o;
    logic [msg_width_p-1:0] req0_resp_o;
    logic                   req0_resp_v_o;
    logic                   req0_resp_ready_i;

    logic [msg_width_p-1:0] req1_cmd_i;
    logic                   req1_cmd_v_i;
    logic                   req1_cmd_yumi_o;
    logic [msg_width_p-1:0] req1_resp_o;
    logic                   req1_resp_v_o;
    logic                   req1_resp_ready_i;

    logic [msg_width_p-1:0] mem_cmd_o;
    logic                   mem_cmd_v_o;
    logic                   mem_cmd_yumi_i;
    logic [msg_width_p-1:0] mem_resp_i;
    logic                   mem_resp_v_i;
    logic                   mem_resp_ready_o;

    modport slave (
        input  req0_cmd_i, req0_cmd_v_i, req0_resp_ready_i,
        input  req1_cmd_i, req1_cmd_v_i, req1_resp_ready_i,
        input  mem_cmd_yumi_i, mem_resp_i, mem_resp_v_i,
        output req0_cmd_yumi_o, req0_resp_o, req0_resp_v_o,
        output req1_cmd_yumi_o, req1_resp_o, req1_resp_v_o,
        output mem_cmd_o, mem_cmd_v_o, mem_resp_ready_o
    );

    modport master (
        output req0_cmd_i, req0_cmd_v_i, req0_resp_ready_i,
        output req1_cmd_i, req1_cmd_v_i, req1_resp_ready_i,
        output mem_cmd_yumi_i, mem_resp_i, mem_resp_v_i,
        input  req0_cmd_yumi_o, req0_resp_o, req0_resp_v_o,
        input  req1_cmd_yumi_o, req1_resp_o, req1_resp_v_o,
        input  mem_cmd_o, mem_cmd_v_o, mem_resp_ready_o
    );
endinterface

// File: rtl/bp_nbf_mem_arbiter.sv
// Two-requester CCE memory arbiter (NBF loader = 0, core = 1) with in-order response routing.
// Optional macro BP_NBF_MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
package bp_nbf_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0,
        e_bp_small_cfg   = 2'd1
    } bp_params_e;

    typedef struct packed {
        int unsigned paddr_width;
        int unsigned cce_block_width;
        int unsigned lce_id_width;
        int unsigned lce_assoc;
    } bp_proc_param_s;

    function automatic bp_proc_param_s bp_proc_param(input bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_small_cfg: p = '{paddr_width: 32, cce_block_width: 128, lce_id_width: 2, lce_assoc: 4};
            default:        p = '{paddr_width: 40, cce_block_width: 512, lce_id_width: 4, lce_assoc: 8};
        endcase
        return p;
    endfunction

    // Header: msg type(4) + addr + size(3) + lce id + way id + coherence state(3); then the data block.
    function automatic int unsigned cce_mem_msg_width(input bp_params_e cfg);
        bp_proc_param_s p;
        p = bp_proc_param(cfg);
        return 4 + p.paddr_width + 3 + p.lce_id_width + $clog2(p.lce_assoc) + 3 + p.cce_block_width;
    endfunction

endpackage

module bp_nbf_mem_arbiter
    import bp_nbf_mem_arbiter_pkg::*;
#(
    parameter bp_params_e  bp_params_p       = e_bp_default_cfg,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    bp_nbf_mem_arbiter_if.slave        bus
);

    localparam int unsigned cce_mem_msg_width_lp = cce_mem_msg_width(bp_params_p);
    localparam int unsigned PTR_W = $clog2(max_outstanding_p);
    localparam int unsigned CNT_W = $clog2(max_outstanding_p + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                       lock_q, lock_d;
    logic                         grant_q, grant_d;
    logic                         last_q, last_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [max_outstanding_p-1:0] tags_q, tags_d;

    logic                         full_c, empty_c;
    logic                         sel_c, served_c;
    logic                         mem_cmd_v_c, commit_c;
    logic                         head_c, resp_ready_c, pop_c;
    logic [cce_mem_msg_width_lp-1:0] mem_cmd_c;

    assign full_c  = (count_q == CNT_W'(max_outstanding_p));
    assign empty_c = (count_q == '0);

    // Requester selection when idle
    always_comb begin
`ifdef BP_NBF_MEM_ARB_ROUND_ROBIN_EN
        if (bus.req0_cmd_v_i && bus.req1_cmd_v_i) begin
            sel_c = ~last_q;
        end else begin
            sel_c = bus.req1_cmd_v_i;
        end
`else
        sel_c = ~bus.req0_cmd_v_i & bus.req1_cmd_v_i;
`endif
    end

    // Lock FSM: hold the granted command stable until memory consumes it
    always_comb begin
        lock_d      = lock_q;
        grant_d     = grant_q;
        last_d      = last_q;
        served_c    = sel_c;
        mem_cmd_v_c = 1'b0;
        case (lock_q)
            IDLE: begin
                served_c    = sel_c;
                mem_cmd_v_c = (bus.req0_cmd_v_i | bus.req1_cmd_v_i) & ~full_c;
                if (mem_cmd_v_c && !bus.mem_cmd_yumi_i) begin
                    lock_d  = LOCKED;
                    grant_d = sel_c;
                end
            end
            LOCKED: begin
                served_c    = grant_q;
                mem_cmd_v_c = 1'b1;
                if (bus.mem_cmd_yumi_i) begin
                    lock_d = IDLE;
                end
            end
            default: lock_d = IDLE;
        endcase
        commit_c = mem_cmd_v_c & bus.mem_cmd_yumi_i;
        if (commit_c) begin
            last_d = served_c;
        end
    end

    assign head_c       = tags_q[rd_ptr_q];
    assign resp_ready_c = ~empty_c & (head_c ? bus.req1_resp_ready_i : bus.req0_resp_ready_i);
    assign pop_c        = bus.mem_resp_v_i & resp_ready_c;

    // Tag FIFO of issuing requester IDs; pointers wrap since depth is a power of two
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(commit_c) - CNT_W'(pop_c);
        if (commit_c) begin
            tags_d[wr_ptr_q] = served_c;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_q   <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tags_q   <= '0;
        end else begin
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tags_q   <= tags_d;
        end
    end

    assign mem_cmd_c            = served_c ? bus.req1_cmd_i : bus.req0_cmd_i;
    assign bus.mem_cmd_o        = mem_cmd_c;
    assign bus.mem_cmd_v_o      = mem_cmd_v_c;
    assign bus.req0_cmd_yumi_o  = commit_c & ~served_c;
    assign bus.req1_cmd_yumi_o  = commit_c & served_c;

    assign bus.req0_resp_o      = bus.mem_resp_i;
    assign bus.req1_resp_o      = bus.mem_resp_i;
    assign bus.req0_resp_v_o    = bus.mem_resp_v_i & ~empty_c & ~head_c;
    assign bus.req1_resp_v_o    = bus.mem_resp_v_i & ~empty_c & head_c;
    assign bus.mem_resp_ready_o = resp_ready_c;

    // A response with nothing outstanding means memory broke ordering
    assert property (@(posedge clk_i) disable iff (reset_i) !(bus.mem_resp_v_i && empty_c))
        else $error("bp_nbf_mem_arbiter: memory response with no outstanding command");

endmodule

// File: tb/tb_bp_nbf_mem_arbiter.sv
// Directed bench for bp_nbf_mem_arbiter: reset, single requester, lock hold,
// contention, full, response routing/backpressure and reset mid-operation.
module tb_bp_nbf_mem_arbiter;
    import bp_nbf_mem_arbiter_pkg::*;

    localparam int unsigned W    = cce_mem_msg_width(e_bp_default_cfg);
    localparam int unsigned MAXO = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    bp_nbf_mem_arbiter_if #(.msg_width_p(W)) bus ();

    bp_nbf_mem_arbiter #(
        .bp_params_p      (e_bp_default_cfg),
        .max_outstanding_p(MAXO)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input logic [31:0] v);
        return (W'(1) << (W - 1)) | W'(v);
    endfunction

    task automatic clear_inputs();
        bus.req0_cmd_i        = '0;
        bus.req0_cmd_v_i      = 1'b0;
        bus.req0_resp_ready_i = 1'b0;
        bus.req1_cmd_i        = '0;
        bus.req1_cmd_v_i      = 1'b0;
        bus.req1_resp_ready_i = 1'b0;
        bus.mem_cmd_yumi_i    = 1'b0;
        bus.mem_resp_i        = '0;
        bus.mem_resp_v_i      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.mem_cmd_v_o !== 1'b0) begin bad++; $display("FAIL reset_cmd_v: got %b want 0", bus.mem_cmd_v_o); end
        total++; if ({bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o} !== 2'b00) begin bad++; $display("FAIL reset_yumi: got %b want 00", {bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o}); end
        total++; if ({bus.req0_resp_v_o, bus.req1_resp_v_o, bus.mem_resp_ready_o} !== 3'b000) begin bad++; $display("FAIL reset_resp: got %b want 000", {bus.req0_resp_v_o, bus.req1_resp_v_o, bus.mem_resp_ready_o}); end
        total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", dut.count_q); end
        total++; if (dut.last_q !== 1'b1) begin bad++; $display("FAIL reset_last: got %b want 1", dut.last_q); end
    endtask

    task automatic test_single();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req1_cmd_i     = mk(32'h1000 + k);
            bus.req1_cmd_v_i   = 1'b1;
            bus.mem_cmd_yumi_i = 1'b1;
            #1;
            total++; if (bus.req1_cmd_yumi_o !== 1'b1 || bus.req0_cmd_yumi_o !== 1'b0) begin bad++; $display("FAIL single_yumi[%0d]: got r0=%b r1=%b want r0=0 r1=1", k, bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o); end
            total++; if (bus.mem_cmd_o !== mk(32'h1000 + k)) begin bad++; $display("FAIL single_cmd[%0d]: got %h want %h", k, bus.mem_cmd_o, mk(32'h1000 + k)); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (dut.count_q !== 3'd3) begin bad++; $display("FAIL single_count3: got %0d want 3", dut.count_q); end
        for (int k = 0; k < 3; k++) begin
            bus.mem_resp_i        = mk(32'h5000 + k);
            bus.mem_resp_v_i      = 1'b1;
            bus.req1_resp_ready_i = 1'b1;
            #1;
            total++; if (bus.req1_resp_v_o !== 1'b1 || bus.req0_resp_v_o !== 1'b0) begin bad++; $display("FAIL single_resp_v[%0d]: got r0=%b r1=%b want r0=0 r1=1", k, bus.req0_resp_v_o, bus.req1_resp_v_o); end
            total++; if (bus.req1_resp_o !== mk(32'h5000 + k)) begin bad++; $display("FAIL single_resp_data[%0d]: got %h want %h", k, bus.req1_resp_o, mk(32'h5000 + k)); end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", dut.count_q); end
    endtask

    task automatic test_lock();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = mk(32'hA0A0);
        b = mk(32'hB0B0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.req0_cmd_i     = a;
            bus.req0_cmd_v_i   = 1'b1;
            bus.mem_cmd_yumi_i = (c == 5);
            if (c >= 2) begin
                bus.req1_cmd_i   = b;
                bus.req1_cmd_v_i = 1'b1;
            end
            #1;
            total++; if (bus.mem_cmd_o !== a || bus.mem_cmd_v_o !== 1'b1) begin bad++; $display("FAIL lock_hold[%0d]: got v=%b %h want v=1 %h", c, bus.mem_cmd_v_o, bus.mem_cmd_o, a); end
            total++; if (bus.req0_cmd_yumi_o !== (c == 5) || bus.req1_cmd_yumi_o !== 1'b0) begin bad++; $display("FAIL lock_yumi[%0d]: got r0=%b r1=%b want r0=%b r1=0", c, bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o, (c == 5)); end
        end
        @(negedge clk);
        bus.req0_cmd_v_i   = 1'b0;
        bus.mem_cmd_yumi_i = 1'b1;
        #1;
        total++; if (bus.mem_cmd_o !== b || bus.req1_cmd_yumi_o !== 1'b1) begin bad++; $display("FAIL lock_then_req1: got yumi1=%b %h want yumi1=1 %h", bus.req1_cmd_yumi_o, bus.mem_cmd_o, b); end
        @(negedge clk);
        clear_inputs();
        bus.req0_resp_ready_i = 1'b1;
        bus.req1_resp_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.mem_resp_v_i = 1'b1;
            bus.mem_resp_i   = mk(32'h6000 + k);
            #1;
            total++; if ({bus.req0_resp_v_o, bus.req1_resp_v_o} !== ((k == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL lock_drain[%0d]: got r0=%b r1=%b", k, bus.req0_resp_v_o, bus.req1_resp_v_o); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    // Contention followed by the full condition; exp_q models the tag FIFO
    task automatic test_contention_full();
        int           exp_q[$];
        int           exp;
        int           n0;
        int           n1;
        logic [W-1:0] want;
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req0_cmd_i     = mk(32'h2000 + n0);
            bus.req1_cmd_i     = mk(32'h3000 + n1);
            bus.req0_cmd_v_i   = 1'b1;
            bus.req1_cmd_v_i   = 1'b1;
            bus.mem_cmd_yumi_i = 1'b1;
`ifdef BP_NBF_MEM_ARB_ROUND_ROBIN_EN
            exp = k % 2;
`else
            exp = 0;
`endif
            want = (exp == 1) ? mk(32'h3000 + n1) : mk(32'h2000 + n0);
            #1;
            total++; if (bus.req0_cmd_yumi_o !== (exp == 0) || bus.req1_cmd_yumi_o !== (exp == 1)) begin bad++; $display("FAIL contend_order[%0d]: got r0=%b r1=%b want served=%0d", k, bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o, exp); end
            total++; if (bus.mem_cmd_o !== want) begin bad++; $display("FAIL contend_cmd[%0d]: got %h want %h", k, bus.mem_cmd_o, want); end
            exp_q.push_back(exp);
            if (exp == 0) n0++; else n1++;
        end
        @(negedge clk);
        bus.req1_cmd_v_i   = 1'b0;
        bus.req0_cmd_i     = mk(32'h2000 + n0);
        bus.mem_cmd_yumi_i = 1'b0;
        #1;
        total++; if (bus.mem_cmd_v_o !== 1'b0) begin bad++; $display("FAIL full_block: got cmd_v=%b want 0", bus.mem_cmd_v_o); end
        total++; if (dut.count_q !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", dut.count_q); end
        @(negedge clk);
        bus.req0_resp_ready_i = 1'b1;
        bus.req1_resp_ready_i = 1'b1;
        bus.mem_resp_v_i      = 1'b1;
        bus.mem_resp_i        = mk(32'h7000);
        exp = exp_q.pop_front();
        #1;
        total++; if (bus.mem_cmd_v_o !== 1'b0 || bus.mem_resp_ready_o !== 1'b1) begin bad++; $display("FAIL full_pop_cycle: got cmd_v=%b resp_ready=%b want 0 1", bus.mem_cmd_v_o, bus.mem_resp_ready_o); end
        total++; if (bus.req0_resp_v_o !== (exp == 0) || bus.req1_resp_v_o !== (exp == 1)) begin bad++; $display("FAIL full_pop_route: got r0=%b r1=%b want %0d", bus.req0_resp_v_o, bus.req1_resp_v_o, exp); end
        @(negedge clk);
        bus.mem_resp_v_i   = 1'b0;
        bus.mem_cmd_yumi_i = 1'b1;
        #1;
        total++; if (bus.mem_cmd_v_o !== 1'b1 || bus.req0_cmd_yumi_o !== 1'b1) begin bad++; $display("FAIL full_reissue: got cmd_v=%b yumi0=%b want 1 1", bus.mem_cmd_v_o, bus.req0_cmd_yumi_o); end
        exp_q.push_back(0);
        @(negedge clk);
        bus.req0_cmd_v_i   = 1'b0;
        bus.mem_cmd_yumi_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_resp_v_i = 1'b1;
            bus.mem_resp_i   = mk(32'h7100 + k);
            exp = exp_q.pop_front();
            #1;
            total++; if (bus.req0_resp_v_o !== (exp == 0) || bus.req1_resp_v_o !== (exp == 1)) begin bad++; $display("FAIL full_drain[%0d]: got r0=%b r1=%b want %0d", k, bus.req0_resp_v_o, bus.req1_resp_v_o, exp); end
            @(negedge clk);
        end
        clear_inputs();
        #1;
        total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", dut.count_q); end
    endtask

    task automatic test_routing();
        @(negedge clk);
        bus.req1_cmd_i     = mk(32'h8001);
        bus.req1_cmd_v_i   = 1'b1;
        bus.mem_cmd_yumi_i = 1'b1;
        @(negedge clk);
        bus.req1_cmd_v_i   = 1'b0;
        bus.req0_cmd_i     = mk(32'h8000);
        bus.req0_cmd_v_i   = 1'b1;
        #1;
        total++; if (bus.req0_cmd_yumi_o !== 1'b1) begin bad++; $display("FAIL route_commit0: got %b want 1", bus.req0_cmd_yumi_o); end
        @(negedge clk);
        clear_inputs();
        bus.mem_resp_v_i      = 1'b1;
        bus.mem_resp_i        = mk(32'h9001);
        bus.req0_resp_ready_i = 1'b1;
        bus.req1_resp_ready_i = 1'b0;
        #1;
        total++; if ({bus.req0_resp_v_o, bus.req1_resp_v_o} !== 2'b01) begin bad++; $display("FAIL route_first: got r0=%b r1=%b want r0=0 r1=1", bus.req0_resp_v_o, bus.req1_resp_v_o); end
        total++; if (bus.mem_resp_ready_o !== 1'b0) begin bad++; $display("FAIL route_backpressure: got %b want 0", bus.mem_resp_ready_o); end
        @(negedge clk);
        #1;
        total++; if (dut.count_q !== 3'd2) begin bad++; $display("FAIL route_no_pop: got %0d want 2", dut.count_q); end
        bus.req1_resp_ready_i = 1'b1;
        #1;
        total++; if (bus.mem_resp_ready_o !== 1'b1 || bus.req1_resp_o !== mk(32'h9001)) begin bad++; $display("FAIL route_release: got ready=%b %h", bus.mem_resp_ready_o, bus.req1_resp_o); end
        @(negedge clk);
        bus.mem_resp_i = mk(32'h9000);
        #1;
        total++; if ({bus.req0_resp_v_o, bus.req1_resp_v_o} !== 2'b10 || bus.req0_resp_o !== mk(32'h9000)) begin bad++; $display("FAIL route_second: got r0=%b r1=%b %h", bus.req0_resp_v_o, bus.req1_resp_v_o, bus.req0_resp_o); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL route_count0: got %0d want 0", dut.count_q); end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.req1_cmd_i     = mk(32'hC001);
        bus.req1_cmd_v_i   = 1'b1;
        bus.mem_cmd_yumi_i = 1'b1;
        @(negedge clk);
        bus.req1_cmd_i     = mk(32'hC002);
        @(negedge clk);
        bus.req1_cmd_v_i   = 1'b0;
        bus.mem_cmd_yumi_i = 1'b0;
        bus.req0_cmd_i     = mk(32'hC000);
        bus.req0_cmd_v_i   = 1'b1;
        @(negedge clk);
        #1;
        total++; if (dut.lock_q !== 1'b1 || dut.count_q !== 3'd2) begin bad++; $display("FAIL midop_setup: got lock=%b count=%0d want 1 2", dut.lock_q, dut.count_q); end
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({bus.mem_cmd_v_o, bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o, bus.req0_resp_v_o, bus.req1_resp_v_o, bus.mem_resp_ready_o} !== 6'b0) begin bad++; $display("FAIL midop_outputs: got %b want 000000", {bus.mem_cmd_v_o, bus.req0_cmd_yumi_o, bus.req1_cmd_yumi_o, bus.req0_resp_v_o, bus.req1_resp_v_o, bus.mem_resp_ready_o}); end
        total++; if (dut.count_q !== 3'd0 || dut.lock_q !== 1'b0) begin bad++; $display("FAIL midop_state: got count=%0d lock=%b want 0 0", dut.count_q, dut.lock_q); end
        @(negedge clk);
        bus.req0_cmd_i     = mk(32'hD000);
        bus.req0_cmd_v_i   = 1'b1;
        bus.mem_cmd_yumi_i = 1'b1;
        #1;
        total++; if (bus.mem_cmd_v_o !== 1'b1 || bus.req0_cmd_yumi_o !== 1'b1 || bus.mem_cmd_o !== mk(32'hD000)) begin bad++; $display("FAIL midop_fresh: got v=%b yumi0=%b %h", bus.mem_cmd_v_o, bus.req0_cmd_yumi_o, bus.mem_cmd_o); end
        @(negedge clk);
        clear_inputs();
        bus.req0_resp_ready_i = 1'b1;
        bus.mem_resp_v_i      = 1'b1;
        bus.mem_resp_i        = mk(32'hE000);
        #1;
        total++; if (bus.req0_resp_v_o !== 1'b1 || bus.mem_resp_ready_o !== 1'b1) begin bad++; $display("FAIL midop_resp: got r0_v=%b ready=%b want 1 1", bus.req0_resp_v_o, bus.mem_resp_ready_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_lock();
        test_contention_full();
        test_routing();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
